// File: rtl/csi2_pkt_handler.sv
// CSI-2 packet stage: header parse, payload stream with byte-accurate tkeep.
// Define CSI2_PKT_ECC_CHECK_EN to enable the header ECC check.
module csi2_pkt_handler #(
  parameter int DATA_LANES = 4
) (
  input  logic                       byte_clk_i,
  input  logic                       rst_n_i,
  input  logic [DATA_LANES-1:0][7:0] word_i,
  input  logic                       valid_i,
  output logic                       pkt_done_o,
  output logic                       hdr_valid_o,
  output logic [1:0]                 vc_o,
  output logic [5:0]                 data_type_o,
  output logic [15:0]                word_count_o,
  output logic                       ecc_err_o,
  output logic [31:0]                pkt_tdata_o,
  output logic [3:0]                 pkt_tkeep_o,
  output logic                       pkt_tvalid_o,
  output logic                       pkt_tlast_o
);

  if (DATA_LANES != 4) begin : g_bad_lanes
    $error("csi2_pkt_handler: only DATA_LANES=4 is supported");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0] word_w;
  logic [16:0] bytes_left_q, bytes_left_d;
  logic [16:0] pay_w;
  logic [3:0]  keep_w;
  logic [31:0] mask_w;
  logic        short_w;
  logic        ecc_bad_w;

  logic        done_q, done_d;
  logic        hdr_q, hdr_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d;
  logic [31:0] tdata_q, tdata_d;
  logic [3:0]  tkeep_q, tkeep_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;

  assign word_w  = word_i;
  assign short_w = (word_w[5:4] == 2'b00);

`ifdef CSI2_PKT_ECC_CHECK_EN
  logic [23:0] ecc_di_w;
  logic [5:0]  ecc_w;
  logic        ecc_err_q;
  logic [1:0]  unused_ecc_w;

  assign ecc_di_w = word_w[23:0];
  assign unused_ecc_w = word_w[31:30];

  always_comb begin
    ecc_w[0] = ^(ecc_di_w & 24'hF12CB7);
    ecc_w[1] = ^(ecc_di_w & 24'hF2555B);
    ecc_w[2] = ^(ecc_di_w & 24'h749A6D);
    ecc_w[3] = ^(ecc_di_w & 24'hB8E38E);
    ecc_w[4] = ^(ecc_di_w & 24'hDF03F0);
    ecc_w[5] = ^(ecc_di_w & 24'hEFFC00);
  end

  assign ecc_bad_w = (ecc_w != word_w[29:24]);

  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ecc_err_q <= 1'b0;
    end else begin
      ecc_err_q <= (state_q == IDLE) && valid_i && ecc_bad_w;
    end
  end

  assign ecc_err_o = ecc_err_q;
`else
  logic [7:0] unused_ecc_w;

  assign unused_ecc_w = word_w[31:24];
  assign ecc_bad_w    = 1'b0;
  assign ecc_err_o    = 1'b0;
`endif

  // Payload bytes still owed once the two CRC bytes are set aside.
  assign pay_w = (bytes_left_q > 17'd2) ? (bytes_left_q - 17'd2) : 17'd0;

  always_comb begin
    keep_w = 4'h0;
    unique case (1'b1)
      (pay_w >= 17'd4): keep_w = 4'hF;
      (pay_w == 17'd3): keep_w = 4'h7;
      (pay_w == 17'd2): keep_w = 4'h3;
      (pay_w == 17'd1): keep_w = 4'h1;
      default:          keep_w = 4'h0;
    endcase
  end

  assign mask_w = {{8{keep_w[3]}}, {8{keep_w[2]}},
                   {8{keep_w[1]}}, {8{keep_w[0]}}};

  always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      bytes_left_q <= '0;
      done_q       <= 1'b0;
      hdr_q        <= 1'b0;
      vc_q         <= '0;
      dt_q         <= '0;
      wc_q         <= '0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      done_q       <= done_d;
      hdr_q        <= hdr_d;
      vc_q         <= vc_d;
      dt_q         <= dt_d;
      wc_q         <= wc_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = (short_w || ecc_bad_w) ? FLUSH : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!valid_i) begin
          state_d = IDLE;
        end else if (bytes_left_q <= 17'd4) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bytes_left_d = bytes_left_q;
    done_d       = 1'b0;
    hdr_d        = 1'b0;
    vc_d         = vc_q;
    dt_d         = dt_q;
    wc_d         = wc_q;
    tdata_d      = '0;
    tkeep_d      = '0;
    tvalid_d     = 1'b0;
    tlast_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          hdr_d = 1'b1;
          vc_d  = word_w[7:6];
          dt_d  = word_w[5:0];
          wc_d  = word_w[23:8];
          if (short_w || ecc_bad_w) begin
            done_d       = 1'b1;
            bytes_left_d = '0;
          end else begin
            bytes_left_d = {1'b0, word_w[23:8]} + 17'd2;
          end
        end
      end
      PAYLOAD: begin
        if (valid_i) begin
          if (pay_w != 17'd0) begin
            tvalid_d = 1'b1;
            tkeep_d  = keep_w;
            tlast_d  = (pay_w <= 17'd4);
            tdata_d  = word_w & mask_w;
          end
          bytes_left_d = (bytes_left_q > 17'd4) ?
                         (bytes_left_q - 17'd4) : 17'd0;
          done_d = (bytes_left_q <= 17'd4);
        end else begin
          // Truncated: close an open payload with an empty last beat.
          tvalid_d     = (pay_w != 17'd0);
          tlast_d      = (pay_w != 17'd0);
          done_d       = 1'b1;
          bytes_left_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign pkt_done_o   = done_q;
  assign hdr_valid_o  = hdr_q;
  assign vc_o         = vc_q;
  assign data_type_o  = dt_q;
  assign word_count_o = wc_q;
  assign pkt_tdata_o  = tdata_q;
  assign pkt_tkeep_o  = tkeep_q;
  assign pkt_tvalid_o = tvalid_q;
  assign pkt_tlast_o  = tlast_q;

endmodule

// File: tb/tb_csi2_pkt_handler.sv
// Bench for csi2_pkt_handler: directed test-plan packets then random ones,
// checked cycle by cycle against a packet-level byte-index model.
module tb_csi2_pkt_handler;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0][7:0] word;
  logic            valid;
  logic            pkt_done;
  logic            hdr_valid;
  logic [1:0]      vc;
  logic [5:0]      dt;
  logic [15:0]     wc;
  logic            ecc_err;
  logic [31:0]     tdata;
  logic [3:0]      tkeep;
  logic            tvalid;
  logic            tlast;

  int checks = 0;
  int errors = 0;

  logic [1:0]  m_vc;
  logic [5:0]  m_dt;
  logic [15:0] m_wc;

  csi2_pkt_handler #(.DATA_LANES(4)) dut (
    .byte_clk_i   (clk),
    .rst_n_i      (rst_n),
    .word_i       (word),
    .valid_i      (valid),
    .pkt_done_o   (pkt_done),
    .hdr_valid_o  (hdr_valid),
    .vc_o         (vc),
    .data_type_o  (dt),
    .word_count_o (wc),
    .ecc_err_o    (ecc_err),
    .pkt_tdata_o  (tdata),
    .pkt_tkeep_o  (tkeep),
    .pkt_tvalid_o (tvalid),
    .pkt_tlast_o  (tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit hv, input bit done,
                            input bit ee, input bit tv, input bit tl,
                            input logic [3:0] keep, input logic [31:0] data);
    chk({tag, ":hdr_valid"}, 32'(hdr_valid), 32'(hv));
    chk({tag, ":pkt_done"}, 32'(pkt_done), 32'(done));
    chk({tag, ":ecc_err"}, 32'(ecc_err), 32'(ee));
    chk({tag, ":tvalid"}, 32'(tvalid), 32'(tv));
    chk({tag, ":tlast"}, 32'(tlast), 32'(tl));
    chk({tag, ":tkeep"}, 32'(tkeep), 32'(keep));
    chk({tag, ":tdata"}, tdata, data);
    chk({tag, ":vc"}, 32'(vc), 32'(m_vc));
    chk({tag, ":dt"}, 32'(dt), 32'(m_dt));
    chk({tag, ":wc"}, 32'(wc), 32'(m_wc));
  endtask

  // Hamming parity sets over the 24 header bits, one list per ECC bit.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    int p0[$] = '{0,1,2,4,5,7,10,11,13,16,20,21,22,23};
    int p1[$] = '{0,1,3,4,6,8,10,12,14,17,20,21,22,23};
    int p2[$] = '{0,2,3,5,6,9,11,12,15,18,20,21,22};
    int p3[$] = '{1,2,3,7,8,9,13,14,15,19,20,21,23};
    int p4[$] = '{4,5,6,7,8,9,16,17,18,19,20,22,23};
    int p5[$] = '{10,11,12,13,14,15,16,17,18,19,21,22,23};
    logic [5:0] e;
    e = '0;
    foreach (p0[i]) e[0] ^= d[p0[i]];
    foreach (p1[i]) e[1] ^= d[p1[i]];
    foreach (p2[i]) e[2] ^= d[p2[i]];
    foreach (p3[i]) e[3] ^= d[p3[i]];
    foreach (p4[i]) e[4] ^= d[p4[i]];
    foreach (p5[i]) e[5] ^= d[p5[i]];
    return e;
  endfunction

  task automatic idle_cycle(input string tag);
    valid = 1'b0;
    word  = 32'($urandom);
    tick();
    expect_out(tag, 0, 0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic flush_tail;
    valid = 1'b1;
    word  = 32'($urandom);
    tick();
    expect_out("flush", 0, 0, 0, 0, 0, 4'h0, 32'h0);
    idle_cycle("flush_exit");
  endtask

  // trunc < 0: complete packet; otherwise valid drops after trunc words.
  task automatic run_pkt(input string name, input logic [1:0] pvc,
                         input logic [5:0] pdt, input int pwc,
                         input int trunc, input bit bad_ecc);
    logic [15:0] wc16;
    logic [23:0] di;
    logic [5:0]  ecc;
    logic [7:0]  b;
    logic [3:0]  keep;
    logic [31:0] w;
    logic [31:0] data;
    int          nw;
    int          nsend;
    int          flip;
    bit          drop;
    bit          beat;
    bit          shrt;
    wc16 = pwc[15:0];
    di   = {wc16, pvc, pdt};
    ecc  = ecc6(di);
    flip = $urandom_range(0, 5);
    if (bad_ecc) ecc[flip] = ~ecc[flip];
`ifdef CSI2_PKT_ECC_CHECK_EN
    drop = bad_ecc;
`else
    drop = 1'b0;
`endif
    shrt = (pdt < 6'h10);
    m_vc = pvc;
    m_dt = pdt;
    m_wc = wc16;
    valid = 1'b1;
    word  = {2'($urandom), ecc, di};
    tick();
    expect_out({name, ":hdr"}, 1, drop || shrt, drop, 0, 0, 4'h0, 32'h0);
    if (drop || shrt) begin
      flush_tail();
      return;
    end
    nw    = (pwc + 1) / 4 + 1;
    nsend = (trunc >= 0) ? trunc : nw;
    for (int k = 0; k < nsend; k++) begin
      w    = '0;
      data = '0;
      keep = '0;
      for (int j = 0; j < 4; j++) begin
        b = 8'($urandom);
        w[8*j +: 8] = b;
        if (4 * k + j < pwc) begin
          keep[j] = 1'b1;
          data[8*j +: 8] = b;
        end
      end
      beat  = (4 * k < pwc);
      word  = w;
      valid = 1'b1;
      tick();
      expect_out($sformatf("%s:w%0d", name, k), 0, k == nw - 1, 0,
                 beat, beat && (4 * k + 4 >= pwc), keep, data);
    end
    if (trunc >= 0) begin
      beat  = (4 * nsend < pwc);
      valid = 1'b0;
      word  = 32'($urandom);
      tick();
      expect_out({name, ":trunc"}, 0, 1, 0, beat, beat, 4'h0, 32'h0);
    end else begin
      flush_tail();
    end
  endtask

  initial begin
    int rwc;
    int rtr;
    int rnw;
    valid = 1'b0;
    word  = '0;
    m_vc  = '0;
    m_dt  = '0;
    m_wc  = '0;
    tick();
    tick();
    expect_out("reset", 0, 0, 0, 0, 0, 4'h0, 32'h0);
    rst_n = 1'b1;
    idle_cycle("post_reset");

    run_pkt("short", 2'd0, 6'h00, 1, -1, 0);
    run_pkt("wc8", 2'd1, 6'h2A, 8, -1, 0);
    run_pkt("wc7", 2'd2, 6'h2A, 7, -1, 0);
    run_pkt("wc0", 2'd3, 6'h2B, 0, -1, 0);
    run_pkt("badecc", 2'd0, 6'h2A, 4, -1, 1);
    run_pkt("trunc16", 2'd1, 6'h2C, 16, 2, 0);
    run_pkt("wc1", 2'd0, 6'h1E, 1, -1, 0);
    run_pkt("wc3", 2'd0, 6'h1E, 3, -1, 0);

    // Reset in the middle of a WC=16 packet.
    valid = 1'b1;
    word  = {ecc6(24'h00102B), 24'h00102B};
    tick();
    word = 32'($urandom);
    tick();
    word = 32'($urandom);
    tick();
    chk("mid:tvalid_before_reset", 32'(tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    m_vc = '0;
    m_dt = '0;
    m_wc = '0;
    expect_out("mid_reset", 0, 0, 0, 0, 0, 4'h0, 32'h0);
    valid = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_cycle("after_reset");
    run_pkt("post_rst", 2'd2, 6'h24, 5, -1, 0);

    for (int n = 0; n < 40; n++) begin
      rwc = $urandom_range(0, 40);
      rnw = (rwc + 1) / 4 + 1;
      rtr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rnw - 1) : -1;
      run_pkt($sformatf("rnd%0d", n), 2'($urandom), 6'($urandom), rwc,
              rtr, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) idle_cycle("gap");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
